// File: rtl/bus_mem_model.sv
// bus_mem_model: parametrised single-port 32-bit word memory slave for the CPU bus.
// Provides base-address decode, wait-state generation, byte-lane merging and a
// sticky fault flag.
// Optional macro BUS_MEM_RANDOM_WAIT_EN: a 16-bit LFSR picks a pseudo-random
// 0..WAIT_STATES stall per transfer instead of a fixed WAIT_STATES stall.
module bus_mem_model #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        fault
);

    localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SpanBytes = 32'(DEPTH_WORDS) << 2;

    logic [31:0]     mem_q [DEPTH_WORDS];
    logic [31:0]     off;
    logic            in_range;
    logic [IdxW-1:0] idx;
    logic            req;
    logic            accept;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      wait_target;
    logic [31:0]     readdata_q, readdata_d;
    logic            fault_q, fault_d;
    logic            mem_we;
    logic [31:0]     wr_word;

    // Contents are zeroed at time 0 and deliberately untouched by reset.
    initial begin
        for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] = '0;
    end

`ifdef BUS_MEM_RANDOM_WAIT_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR (taps 16,14,13,11), stepped once per accepted transfer.
    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign wait_target = 4'(lfsr_q % (16'(WAIT_STATES) + 16'd1));
`else
    assign wait_target = 4'(WAIT_STATES);
`endif

    // Address decode: offset from base wraps in 32 bits; byte offset ignored for the index.
    always_comb begin
        off      = address - BASE_ADDR;
        in_range = off < SpanBytes;
        idx      = off[IdxW+1:2];
    end

    // Handshake: stall until the wait counter reaches its target for this transfer.
    always_comb begin
        req         = read | write;
        waitrequest = req && (cnt_q != wait_target);
        accept      = req && !waitrequest;
        if (!req || accept) cnt_d = '0;
        else                cnt_d = cnt_q + 4'd1;
    end

    // Transfer effects at acceptance: byte-merged write, read capture, fault detection.
    always_comb begin
        readdata_d = readdata_q;
        fault_d    = fault_q;
        mem_we     = 1'b0;
        wr_word    = mem_q[idx];
        if (accept) begin
            // Address 0 is the CPU idle fetch and must not raise a fault.
            if (!in_range && (address != '0)) fault_d = 1'b1;
            if (read && write)                fault_d = 1'b1;
            if (address[1:0] != 2'b00)        fault_d = 1'b1;
            if (write) begin
                // A simultaneous read is ignored; readdata keeps its last value.
                mem_we = in_range && (byteenable != 4'b0000);
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) wr_word[8*b +: 8] = writedata[8*b +: 8];
                end
            end else begin
                readdata_d = in_range ? mem_q[idx] : '0;
            end
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            readdata_q <= '0;
            fault_q    <= 1'b0;
`ifdef BUS_MEM_RANDOM_WAIT_EN
            lfsr_q     <= 16'hACE1;
`endif
        end else begin
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            fault_q    <= fault_d;
`ifdef BUS_MEM_RANDOM_WAIT_EN
            lfsr_q     <= lfsr_d;
`endif
        end
    end

    // Memory array write port; a reset edge never commits.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem_q[idx] <= wr_word;
    end

    assign readdata = readdata_q;
    assign fault    = fault_q;

endmodule
